// File: rtl/game_level_ctrl.sv
// game_level_ctrl: level/round/guess/timer progression for the number-guessing
// game. It owns the wrong-guess counter, the round counter and the per-level
// countdown, and decodes the status outputs from registered state only.
//
// Inputs are sampled on the rising clock edge:
//   - confirm is a level signal. A guess is its rising edge, found by comparing
//     it with the value registered on the previous cycle.
//   - tick is a one-cycle pulse per second.
//   - guess_ok is only looked at in the cycle in which a press is detected.
module game_level_ctrl #(
  parameter int NUM_LEVELS       = 3,
  parameter int ROUNDS_PER_LEVEL = 4,
  parameter int BASE_GUESSES     = 3,
  parameter int BASE_TIME        = 30,
  parameter int TIMER_W          = 7,
  localparam int LVL_W = ($clog2(NUM_LEVELS + 1) > 1) ? $clog2(NUM_LEVELS + 1) : 1,
  localparam int RND_W = $clog2(ROUNDS_PER_LEVEL + 1),
  localparam int GW    = $clog2(BASE_GUESSES + NUM_LEVELS)
) (
  input  logic               clk,
  input  logic               restart,
  input  logic               tick,
  input  logic               confirm,
  input  logic               guess_ok,
  output logic [LVL_W-1:0]   level,
  output logic [LVL_W-1:0]   max_digit,
  output logic [RND_W-1:0]   round,
  output logic [GW-1:0]      guesses_left,
  output logic [TIMER_W-1:0] time_left,
  output logic [1:0]         WINorLOSE,
  output logic               level_up
);

  typedef enum logic [1:0] {
    S_PLAY     = 2'd0,
    S_LEVEL_UP = 2'd1,
    S_WIN      = 2'd2,
    S_LOSE     = 2'd3
  } state_t;

  localparam logic [TIMER_W-1:0] BASE_T     = TIMER_W'(BASE_TIME);
  localparam logic [RND_W-1:0]   RND_MAX    = RND_W'(ROUNDS_PER_LEVEL);
  localparam logic [LVL_W-1:0]   LAST_LEVEL = LVL_W'(NUM_LEVELS - 1);

  state_t               state_q, state_d;
  logic [LVL_W-1:0]     level_q, level_d;
  logic [RND_W-1:0]     round_q, round_d;
  logic [GW-1:0]        wrong_q, wrong_d;
  logic [TIMER_W-1:0]   time_q, time_d;
  logic                 confirm_q, confirm_d;

  logic                 press;
  logic [GW-1:0]        guess_limit;
  logic                 cleared;
  logic                 out_of_guesses;
  logic                 timeout;

  assign press       = confirm & ~confirm_q;
  assign guess_limit = GW'(BASE_GUESSES) + GW'(level_q);
  assign confirm_d   = confirm;

  // State register: every flop clears at once when restart goes low.
  always_ff @(posedge clk or negedge restart) begin
    if (!restart) begin
      state_q   <= S_PLAY;
      level_q   <= '0;
      round_q   <= '0;
      wrong_q   <= '0;
      time_q    <= BASE_T;
      confirm_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      level_q   <= level_d;
      round_q   <= round_d;
      wrong_q   <= wrong_d;
      time_q    <= time_d;
      confirm_q <= confirm_d;
    end
  end

  // Next state and counters. A press and a tick in the same cycle both update
  // their counters; clearing the level beats a simultaneous timeout.
  always_comb begin
    state_d        = state_q;
    level_d        = level_q;
    round_d        = round_q;
    wrong_d        = wrong_q;
    time_d         = time_q;
    cleared        = 1'b0;
    out_of_guesses = 1'b0;
    timeout        = 1'b0;
    case (state_q)
      S_PLAY: begin
        if (press) begin
          if (guess_ok) begin
            round_d = round_q + RND_W'(1);
            cleared = (round_d == RND_MAX);
          end else begin
            wrong_d        = wrong_q + GW'(1);
            out_of_guesses = (wrong_d == guess_limit);
          end
        end
        // The countdown never goes below zero, even on an unexpected tick.
        if (tick && (time_q != '0)) begin
          time_d  = time_q - TIMER_W'(1);
          timeout = (time_d == '0);
        end
        if (cleared) begin
          state_d = (level_q == LAST_LEVEL) ? S_WIN : S_LEVEL_UP;
        end else if (timeout || out_of_guesses) begin
          state_d = S_LOSE;
        end
      end
      S_LEVEL_UP: begin
        // Load the next level's budgets; presses and ticks are dropped here.
        level_d = level_q + LVL_W'(1);
        round_d = '0;
        wrong_d = '0;
        time_d  = BASE_T * (TIMER_W'(level_q) + TIMER_W'(2));
        state_d = S_PLAY;
      end
      default: begin
        // WIN and LOSE hold everything until restart.
      end
    endcase
  end

  // Output decode from registered state only.
  always_comb begin
    level_up  = 1'b0;
    WINorLOSE = 2'b11;
    max_digit = level_q + LVL_W'(1);
    case (state_q)
      S_LEVEL_UP: level_up = 1'b1;
      S_WIN: begin
        WINorLOSE = 2'b01;
        max_digit = '0;
      end
      S_LOSE: begin
        WINorLOSE = 2'b00;
        max_digit = '0;
      end
      default: begin
      end
    endcase
  end

  assign level        = level_q;
  assign round        = round_q;
  assign time_left    = time_q;
  assign guesses_left = guess_limit - wrong_q;

endmodule

// File: tb/tb_game_level_ctrl.sv
// Directed bench for game_level_ctrl with default parameters. Inputs change
// 1 ns after a rising edge and outputs are checked there as well, well away
// from the next active edge.
module tb_game_level_ctrl;

  logic       clk;
  logic       restart;
  logic       tick;
  logic       confirm;
  logic       guess_ok;
  logic [1:0] level;
  logic [1:0] max_digit;
  logic [2:0] round;
  logic [2:0] guesses_left;
  logic [6:0] time_left;
  logic [1:0] WINorLOSE;
  logic       level_up;

  int n_checks = 0;
  int n_fail   = 0;
  int lu_cnt   = 0;
  int lu_base;

  game_level_ctrl dut (
    .clk          (clk),
    .restart      (restart),
    .tick         (tick),
    .confirm      (confirm),
    .guess_ok     (guess_ok),
    .level        (level),
    .max_digit    (max_digit),
    .round        (round),
    .guesses_left (guesses_left),
    .time_left    (time_left),
    .WINorLOSE    (WINorLOSE),
    .level_up     (level_up)
  );

  // Clock: 10 ns period.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count level_up pulses, sampled on the falling edge.
  always @(negedge clk) begin
    if (level_up === 1'b1) lu_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // One press: confirm high for one edge (detected), then low for one edge.
  task automatic press(input logic ok);
    confirm  = 1'b1;
    guess_ok = ok;
    cyc();
    confirm  = 1'b0;
    guess_ok = 1'b0;
    cyc();
  endtask

  task automatic do_tick();
    tick = 1'b1;
    cyc();
    tick = 1'b0;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #3 restart = 1'b0;
    #2 restart = 1'b1;
    cyc();
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, ".level"},   32'(level),        0);
    chk({tag, ".maxd"},    32'(max_digit),    1);
    chk({tag, ".round"},   32'(round),        0);
    chk({tag, ".guesses"}, 32'(guesses_left), 3);
    chk({tag, ".time"},    32'(time_left),    30);
    chk({tag, ".wl"},      32'(WINorLOSE),    3);
    chk({tag, ".lu"},      32'(level_up),     0);
  endtask

  initial begin
    restart  = 1'b0;
    tick     = 1'b0;
    confirm  = 1'b0;
    guess_ok = 1'b0;
    #12;
    chk_reset_vals("rst");
    restart = 1'b1;
    cyc();
    chk_reset_vals("rst_rel");

    // Level 0 cleared by 4 correct presses, then levels 1 and 2 to WIN.
    lu_base = lu_cnt;
    for (int i = 0; i < 3; i++) press(1'b1);
    chk("l0_round3", 32'(round), 3);
    confirm  = 1'b1;
    guess_ok = 1'b1;
    cyc();
    confirm  = 1'b0;
    chk("lu_pulse",     32'(level_up), 1);
    chk("lu_old_level", 32'(level),    0);
    cyc();
    chk("lu_low",   32'(level_up),     0);
    chk("l1_level", 32'(level),        1);
    chk("l1_maxd",  32'(max_digit),    2);
    chk("l1_round", 32'(round),        0);
    chk("l1_guess", 32'(guesses_left), 4);
    chk("l1_time",  32'(time_left),    60);
    chk("l1_wl",    32'(WINorLOSE),    3);
    chk("l1_lucnt", 32'(lu_cnt - lu_base), 1);
    for (int i = 0; i < 4; i++) press(1'b1);
    chk("l2_level", 32'(level),        2);
    chk("l2_time",  32'(time_left),    90);
    chk("l2_guess", 32'(guesses_left), 5);
    for (int i = 0; i < 3; i++) press(1'b1);
    chk("pre_win_wl",    32'(WINorLOSE), 3);
    chk("pre_win_round", 32'(round),     3);
    press(1'b1);
    chk("win_wl",    32'(WINorLOSE), 1);
    chk("win_maxd",  32'(max_digit), 0);
    chk("win_round", 32'(round),     4);
    press(1'b0);
    do_tick();
    cyc();
    chk("win_sticky_wl",   32'(WINorLOSE),    1);
    chk("win_sticky_time", 32'(time_left),    90);
    chk("win_sticky_gl",   32'(guesses_left), 5);
    chk("win_lucnt",       32'(lu_cnt - lu_base), 2);

    // Three wrong guesses at level 0 lose the game; LOSE ignores inputs.
    do_reset();
    chk_reset_vals("rst2");
    press(1'b0);
    press(1'b0);
    chk("wrong2_gl", 32'(guesses_left), 1);
    chk("wrong2_wl", 32'(WINorLOSE),    3);
    press(1'b0);
    chk("lose_wl",   32'(WINorLOSE),    0);
    chk("lose_gl",   32'(guesses_left), 0);
    chk("lose_maxd", 32'(max_digit),    0);
    press(1'b1);
    press(1'b0);
    do_tick();
    chk("lose_frz_wl",    32'(WINorLOSE),    0);
    chk("lose_frz_round", 32'(round),        0);
    chk("lose_frz_gl",    32'(guesses_left), 0);
    chk("lose_frz_time",  32'(time_left),    30);

    // Timeout: 29 ticks keep playing, the 30th loses.
    do_reset();
    for (int i = 0; i < 29; i++) do_tick();
    chk("t29_time", 32'(time_left), 1);
    chk("t29_wl",   32'(WINorLOSE), 3);
    do_tick();
    chk("t30_time", 32'(time_left), 0);
    chk("t30_wl",   32'(WINorLOSE), 0);
    do_tick();
    chk("t31_time", 32'(time_left), 0);

    // Clearing press in the same cycle as the final tick wins over timeout.
    do_reset();
    for (int i = 0; i < 3; i++) press(1'b1);
    for (int i = 0; i < 29; i++) do_tick();
    chk("race_pre_time", 32'(time_left), 1);
    confirm  = 1'b1;
    guess_ok = 1'b1;
    tick     = 1'b1;
    cyc();
    confirm  = 1'b0;
    guess_ok = 1'b0;
    tick     = 1'b0;
    chk("race_lu",   32'(level_up),  1);
    chk("race_wl",   32'(WINorLOSE), 3);
    cyc();
    chk("race_level", 32'(level),     1);
    chk("race_time",  32'(time_left), 60);
    chk("race_wl2",   32'(WINorLOSE), 3);

    // confirm held high for 10 cycles counts as one wrong guess.
    do_reset();
    confirm  = 1'b1;
    guess_ok = 1'b0;
    for (int i = 0; i < 10; i++) cyc();
    confirm  = 1'b0;
    cyc();
    chk("hold_gl", 32'(guesses_left), 2);
    chk("hold_wl", 32'(WINorLOSE),    3);

    // Asynchronous restart mid level 2.
    do_reset();
    for (int i = 0; i < 9; i++) press(1'b1);
    do_tick();
    chk("mid_l2_level", 32'(level),     2);
    chk("mid_l2_round", 32'(round),     1);
    chk("mid_l2_time",  32'(time_left), 89);
    #2 restart = 1'b0;
    #1;
    chk_reset_vals("async");
    #1 restart = 1'b1;
    cyc();
    press(1'b1);
    chk("post_rst_level", 32'(level), 0);
    chk("post_rst_round", 32'(round), 1);
    chk("post_rst_time",  32'(time_left), 30);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/game_level_ctrl.md
# game_level_ctrl

Parametrised game-progression controller for the number-guessing game. It generalises the fixed three-difficulty flow to `NUM_LEVELS` levels, each with `ROUNDS_PER_LEVEL` rounds. It owns the wrong-guess counter, round counter and per-level countdown timer internally, and ends the game on timeout even when no guess is pending. It sits between the guess comparator, the 1 Hz tick generator and the display/LED drivers.

## Interface
- `NUM_LEVELS`, 3: number of levels; level L is 0-based.
- `ROUNDS_PER_LEVEL`, 4: correct guesses required to clear a level.
- `BASE_GUESSES`, 3: wrong-guess limit for level L is `BASE_GUESSES+L`.
- `BASE_TIME`, 30: time budget for level L is `BASE_TIME*(L+1)` ticks.
- `TIMER_W`, 7: timer width. `BASE_TIME*NUM_LEVELS` must be below `2**TIMER_W`.
- Derived widths:
  - `LVL_W = max(1,$clog2(NUM_LEVELS+1))`
  - `RND_W = $clog2(ROUNDS_PER_LEVEL+1)`
  - `GW = $clog2(BASE_GUESSES+NUM_LEVELS)`

Ports:
- `clk` in 1: single clock; all state changes on its rising edge.
- `restart` in 1: asynchronous, active-low reset.
- `tick` in 1: one-cycle pulse per second, synchronous to `clk`.
- `confirm` in 1: level signal from the confirm button; each rising edge is one guess.
- `guess_ok` in 1: comparator result; sampled only in the cycle a confirm edge is detected.
- `level` out LVL_W: current level.
- `max_digit` out LVL_W: digits in the target number, equal to `level+1`; 0 in WIN/LOSE.
- `round` out RND_W: correct guesses so far in this level.
- `guesses_left` out GW: `BASE_GUESSES+level-wrong`.
- `time_left` out TIMER_W: remaining ticks in this level.
- `WINorLOSE` out 2: 2'b11 playing, 2'b01 win, 2'b00 lose.
- `level_up` out 1: one-cycle pulse when a non-final level is cleared.

## Operation
- States: PLAY, LEVEL_UP, WIN, LOSE.
- Reset values:
  - state PLAY, level 0, round 0, wrong 0
  - time_left `BASE_TIME`, guesses_left `BASE_GUESSES`
  - max_digit 1, WINorLOSE 2'b11, level_up 0
  - internal `confirm_q` 0
- Edge detect: `press = confirm & ~confirm_q`. `confirm_q <= confirm` every cycle in all states. Holding confirm high counts as one press.
- PLAY, on press with `guess_ok=1`:
  - round+1.
  - If round reaches `ROUNDS_PER_LEVEL`: go to WIN if `level==NUM_LEVELS-1`, else go to LEVEL_UP.
- PLAY, on press with `guess_ok=0`:
  - wrong+1.
  - If wrong reaches `BASE_GUESSES+level`, go to LOSE.
- PLAY, on tick:
  - time_left-1.
  - If it reaches 0, go to LOSE.
  - A tick with time_left already 0 cannot occur in PLAY.
- Same-cycle press and tick in PLAY:
  - Both counters update.
  - A press result of WIN or LEVEL_UP takes priority over timeout.
  - Otherwise timeout or wrong-limit gives LOSE.
- LEVEL_UP, one cycle:
  - level+1, round 0, wrong 0, time_left `BASE_TIME*(level+2)`, level_up=1.
  - Next state PLAY.
  - press and tick are ignored.
- WIN/LOSE are sticky until `restart` is asserted.
  - press and tick are ignored.
  - level, round, wrong and time_left are frozen.
  - max_digit is 0.
- Arithmetic: all counters are unsigned and never wrap.
  - wrong never exceeds the limit, so guesses_left is never negative.
  - time_left never decrements below 0.

## Timing
- Latency: a confirm rising edge detected at clock edge N updates round/wrong/state at edge N. Outputs reflect it in the cycle after edge N, i.e. 1 cycle from the first sampled-high `confirm`.
- `tick` has the same 1-cycle latency to `time_left`.
- LEVEL_UP adds one cycle. `level_up` is high for exactly that cycle. New-level values are visible the cycle after.
- `restart` low clears all registers immediately, independent of `clk`. The block resumes at the first rising edge after deassertion.
- Outputs are decoded from registers only, with no combinational path from inputs.

## Test plan
Default parameters throughout.
1. Release reset, then 4 presses with `guess_ok=1` → one `level_up` pulse; afterwards level=1, max_digit=2, round=0, guesses_left=4, time_left=60, WINorLOSE=11.
2. At level 0, 3 presses with `guess_ok=0` → WINorLOSE=00, guesses_left=0, max_digit=0; further presses and ticks change nothing.
3. 12 consecutive correct presses → WINorLOSE=01 after the 12th; exactly 2 `level_up` pulses total (none after the final round).
4. No presses, 30 ticks at level 0 → LOSE on the 30th tick, time_left=0; with only 29 ticks the block remains in PLAY with time_left=1.
5. Level 0, round=3, time_left=1, 4th correct press in the same cycle as a tick → LEVEL_UP (not LOSE); then time_left=60. Separately, `confirm` held high for 10 cycles with `guess_ok=0` → wrong increments exactly once (guesses_left 3→2).
6. Mid level 2, pull `restart` low between clock edges → outputs return to reset values before the next clock edge; after release, play restarts at level 0.
